// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants for the prefetch stage and its consumers.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mips_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_INC    = 32'd4;

  // One buffered fetch: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Fall-through sync FIFO of fetch entries with synchronous flush and occupancy count.
// Latency: a push is visible at head the following cycle.
// Backpressure: none internally; the caller's credit scheme keeps it from overflowing.
module prefetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  // Pop only real data; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL) || do_pop);
    head    = mem[rd_ptr];
  end

  // Pointer and count update; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/prefetch_unit.sv
// Sequential instruction prefetch with a credit-bounded FIFO and redirect flush.
// Latency: response to inst_valid 1 cycle; redirect to first target request 1 cycle.
// Backpressure: requests stall while buffered + outstanding reaches DEPTH; responses never stall.
module prefetch_unit
  import mips_pkg::fetch_entry_t;
  import mips_pkg::PC_INC;
  import mips_pkg::NOP_INSTR;
  import mips_pkg::word_align;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = mips_pkg::ADDR_W,
  parameter int                INSTR_W  = mips_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW:0]   CAP = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] target;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_after_rsp;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     count;
  logic              req_fire;
  logic              rsp_take;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // Request channel and credit check: never hold more fetches than the FIFO can absorb.
  always_comb begin
    target         = word_align(redirect_pc);
    imem_req_valid = !reset && !redirect_valid &&
                     (({1'b0, count} + {1'b0, outstanding}) < CAP);
    imem_req_addr  = reset ? RESET_PC : fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
  end

  // Response handling: a response with nothing outstanding is a protocol error and is ignored.
  always_comb begin
    rsp_take              = imem_rsp_valid && !reset && (outstanding != '0);
    outstanding_after_rsp = outstanding - (rsp_take ? ONE : '0);
    push                  = rsp_take && !redirect_valid && (discard == '0);
    push_entry.pc         = rsp_pc;
    push_entry.instr      = imem_rsp_data;
  end

  // Instruction channel: head of FIFO shown directly, zeroed when empty; redirect voids the pop.
  always_comb begin
    inst_valid = !reset && (count != '0);
    pop        = inst_valid && inst_ready && !redirect_valid;
    inst_data  = inst_valid ? head.instr : NOP_INSTR;
    inst_pc    = inst_valid ? head.pc : '0;
  end

  // PC and in-flight bookkeeping; a redirect marks every surviving in-flight fetch as stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= target;
      rsp_pc      <= target;
      outstanding <= outstanding_after_rsp;
      discard     <= outstanding_after_rsp;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_INC;
      if (push)     rsp_pc   <= rsp_pc + PC_INC;
      if (rsp_take && (discard != '0)) discard <= discard - ONE;
      outstanding <= outstanding_after_rsp + (req_fire ? ONE : '0);
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule
